// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffers of the 5-stage core:
// per-boundary field widths, control-bit positions and occupancy encodings.
package pipe_pkg;

    // Control field layout shared by every stage boundary
    localparam int CTRL_W         = 3;
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_WRITE_PC4 = 2;

    // Data field widths per stage boundary
    localparam int IF_ID_DATA_W   = 64;
    localparam int ID_EX_DATA_W   = 133;
    localparam int EX_MEM_DATA_W  = 133;
    localparam int MEM_WB_DATA_W  = 104;

    // Occupancy encodings (value equals the number of held entries)
    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_ONE     = 2'd1;
    localparam logic [1:0] OCC_TWO     = 2'd2;
    localparam logic [1:0] OCC_ILLEGAL = 2'd3;

    // Map the two valid flags to an occupancy code; a skid entry without a
    // main entry cannot occur in normal operation and is flagged as illegal.
    function automatic logic [1:0] occupancy(input logic mainValid, input logic skidValid);
        logic [1:0] occ;
        case ({skidValid, mainValid})
            2'b00:   occ = OCC_EMPTY;
            2'b01:   occ = OCC_ONE;
            2'b11:   occ = OCC_TWO;
            default: occ = OCC_ILLEGAL;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between two pipeline stages. The slave modport is the
// buffer itself; the master modport is the environment driving it.
interface pipe_stage_buf_if #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DATA_W = pipe_pkg::ID_EX_DATA_W
);
    logic              flush;
    logic              inValid;
    logic              inReady;
    logic [CTRL_W-1:0] inCtrl;
    logic [DATA_W-1:0] inData;
    logic              outValid;
    logic              outReady;
    logic [CTRL_W-1:0] outCtrl;
    logic [DATA_W-1:0] outData;
    logic [1:0]        count;

    modport master (
        output flush, inValid, inCtrl, inData, outReady,
        input  inReady, outValid, outCtrl, outData, count
    );

    modport slave (
        input  flush, inValid, inCtrl, inData, outReady,
        output inReady, outValid, outCtrl, outData, count
    );
endinterface

// File: rtl/pipe_stage_buf_edge_reg.sv
// Enabled register with asynchronous active-high reset whose capture edge is
// chosen at elaboration time (falling edge when CLK_NEG=1, rising otherwise).
module pipe_edge_reg #(
    parameter int W       = 1,
    parameter bit CLK_NEG = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (CLK_NEG) begin : gNeg
            // Falling-edge capture with asynchronous clear
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    q <= {W{1'b0}};
                end else if (en) begin
                    q <= d;
                end
            end
        end else begin : gPos
            // Rising-edge capture with asynchronous clear
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= {W{1'b0}};
                end else if (en) begin
                    q <= d;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry
// skid buffer. The main entry drives the outputs directly; the skid entry
// absorbs one entry accepted while downstream stalls, so inReady depends only
// on registered state. Control bits are cleared whenever the main entry
// empties, so bubbles never carry a stray write enable downstream.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = pipe_pkg::CTRL_W,
    parameter int DATA_W  = pipe_pkg::ID_EX_DATA_W,
    parameter bit CLK_NEG = 1'b1
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_buf_if.slave bus
);
    logic              mainValid_r, skidValid_r;
    logic [CTRL_W-1:0] mainCtrl_r, skidCtrl_r;
    logic [DATA_W-1:0] mainData_r, skidData_r;

    logic              accept_s, consume_s;
    logic [1:0]        occ_s;
    logic              mainValidD_s, skidValidD_s;
    logic              mainCtrlEn_s, mainDataEn_s, skidCtrlEn_s, skidDataEn_s;
    logic [CTRL_W-1:0] mainCtrlD_s, skidCtrlD_s;
    logic [DATA_W-1:0] mainDataD_s;

    // Next-state selection for the main and skid entries
    always_comb begin
        accept_s     = bus.inValid & ~skidValid_r;
        consume_s    = mainValid_r & bus.outReady;
        occ_s        = occupancy(mainValid_r, skidValid_r);
        mainValidD_s = mainValid_r;
        skidValidD_s = skidValid_r;
        mainCtrlEn_s = 1'b0;
        mainDataEn_s = 1'b0;
        skidCtrlEn_s = 1'b0;
        skidDataEn_s = 1'b0;
        mainCtrlD_s  = bus.inCtrl;
        mainDataD_s  = bus.inData;
        skidCtrlD_s  = bus.inCtrl;
        if (bus.flush) begin
            // Flush wins over any handshake; data fields are left as they are
            mainValidD_s = 1'b0;
            skidValidD_s = 1'b0;
            mainCtrlEn_s = 1'b1;
            mainCtrlD_s  = {CTRL_W{1'b0}};
            skidCtrlEn_s = 1'b1;
            skidCtrlD_s  = {CTRL_W{1'b0}};
        end else begin
            case (occ_s)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        mainValidD_s = 1'b1;
                        mainCtrlEn_s = 1'b1;
                        mainDataEn_s = 1'b1;
                    end else begin
                        mainValidD_s = 1'b0;
                    end
                end
                OCC_ONE: begin
                    if (accept_s && consume_s) begin
                        mainCtrlEn_s = 1'b1;
                        mainDataEn_s = 1'b1;
                    end else if (accept_s) begin
                        skidValidD_s = 1'b1;
                        skidCtrlEn_s = 1'b1;
                        skidDataEn_s = 1'b1;
                    end else if (consume_s) begin
                        mainValidD_s = 1'b0;
                        mainCtrlEn_s = 1'b1;
                        mainCtrlD_s  = {CTRL_W{1'b0}};
                    end else begin
                        mainValidD_s = 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (consume_s) begin
                        mainCtrlEn_s = 1'b1;
                        mainCtrlD_s  = skidCtrl_r;
                        mainDataEn_s = 1'b1;
                        mainDataD_s  = skidData_r;
                        skidValidD_s = 1'b0;
                        skidCtrlEn_s = 1'b1;
                        skidCtrlD_s  = {CTRL_W{1'b0}};
                    end else begin
                        skidValidD_s = 1'b1;
                    end
                end
                default: begin
                    // Unreachable skid-only state: recover to empty
                    mainValidD_s = 1'b0;
                    skidValidD_s = 1'b0;
                    mainCtrlEn_s = 1'b1;
                    mainCtrlD_s  = {CTRL_W{1'b0}};
                    skidCtrlEn_s = 1'b1;
                    skidCtrlD_s  = {CTRL_W{1'b0}};
                end
            endcase
        end
    end

    pipe_edge_reg #(.W(1), .CLK_NEG(CLK_NEG)) uMainValid (
        .clk(clk), .rst(rst), .en(1'b1), .d(mainValidD_s), .q(mainValid_r));
    pipe_edge_reg #(.W(1), .CLK_NEG(CLK_NEG)) uSkidValid (
        .clk(clk), .rst(rst), .en(1'b1), .d(skidValidD_s), .q(skidValid_r));
    pipe_edge_reg #(.W(CTRL_W), .CLK_NEG(CLK_NEG)) uMainCtrl (
        .clk(clk), .rst(rst), .en(mainCtrlEn_s), .d(mainCtrlD_s), .q(mainCtrl_r));
    pipe_edge_reg #(.W(DATA_W), .CLK_NEG(CLK_NEG)) uMainData (
        .clk(clk), .rst(rst), .en(mainDataEn_s), .d(mainDataD_s), .q(mainData_r));
    pipe_edge_reg #(.W(CTRL_W), .CLK_NEG(CLK_NEG)) uSkidCtrl (
        .clk(clk), .rst(rst), .en(skidCtrlEn_s), .d(skidCtrlD_s), .q(skidCtrl_r));
    pipe_edge_reg #(.W(DATA_W), .CLK_NEG(CLK_NEG)) uSkidData (
        .clk(clk), .rst(rst), .en(skidDataEn_s), .d(bus.inData), .q(skidData_r));

    assign bus.inReady  = ~skidValid_r;
    assign bus.outValid = mainValid_r;
    assign bus.outCtrl  = mainCtrl_r;
    assign bus.outData  = mainData_r;
    assign bus.count    = {1'b0, mainValid_r} + {1'b0, skidValid_r};
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed vector table, hand-written
// reset/flush/edge sequences and a randomized run against a queue model.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int CW = 3;
    localparam int DW = 133;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) busN ();
    pipe_stage_buf_if #(.CTRL_W(CW), .DATA_W(DW)) busP ();

    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CLK_NEG(1'b1)) dutN (
        .clk(clk), .rst(rst), .bus(busN));
    pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CLK_NEG(1'b0)) dutP (
        .clk(clk), .rst(rst), .bus(busP));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          inValid;
        logic          outReady;
        logic          flush;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic          expValid;
        logic [1:0]    expCount;
        logic          expReady;
        logic [CW-1:0] expCtrl;
        logic [DW-1:0] expData;
    } vec_t;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    vec_t   tbl[17];
    entry_t model[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic setV(input int i, input logic iv, input logic orr, input logic fl,
                        input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ev, input logic [1:0] ec, input logic er,
                        input logic [CW-1:0] ectl, input logic [DW-1:0] ed);
        tbl[i].inValid  = iv;   tbl[i].outReady = orr; tbl[i].flush = fl;
        tbl[i].ctrl     = c;    tbl[i].data     = d;
        tbl[i].expValid = ev;   tbl[i].expCount = ec;  tbl[i].expReady = er;
        tbl[i].expCtrl  = ectl; tbl[i].expData  = ed;
    endtask

    // Compare the falling-edge instance against expected values
    task automatic chkN(input string tag, input logic ev, input logic [1:0] ec, input logic er,
                        input logic [CW-1:0] ectl, input logic [DW-1:0] ed);
        chk({tag, ".outValid"}, DW'(busN.outValid), DW'(ev));
        chk({tag, ".count"},    DW'(busN.count),    DW'(ec));
        chk({tag, ".inReady"},  DW'(busN.inReady),  DW'(er));
        chk({tag, ".outCtrl"},  DW'(busN.outCtrl),  DW'(ectl));
        if (ev) chk({tag, ".outData"}, busN.outData, ed);
    endtask

    task automatic driveN(input logic iv, input logic orr, input logic fl,
                          input logic [CW-1:0] c, input logic [DW-1:0] d);
        busN.inValid = iv; busN.outReady = orr; busN.flush = fl;
        busN.inCtrl  = c;  busN.inData   = d;
    endtask

    // Advance past one active edge of the falling-edge instance
    task automatic edgeN();
        @(negedge clk);
        #2;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model.delete();
    endtask

    initial begin
        logic [159:0] r;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic iv, orr, fl;
        entry_t e;

        driveN(1'b0, 1'b0, 1'b0, 3'd0, '0);
        busP.inValid = 1'b0; busP.outReady = 1'b0; busP.flush = 1'b0;
        busP.inCtrl = 3'd0; busP.inData = '0;

        // Reset state
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chkN("reset", 1'b0, 2'd0, 1'b1, 3'd0, '0);
        chk("reset.outData", busN.outData, '0);
        #1 rst = 1'b0;

        //                 iv    or    fl    ctl   data        eV    cnt   rdy   eCtl  eData
        setV( 0, 1'b1, 1'b1, 1'b0, 3'd1, 133'h1,  1'b1, 2'd1, 1'b1, 3'd1, 133'h1);
        setV( 1, 1'b1, 1'b1, 1'b0, 3'd2, 133'h2,  1'b1, 2'd1, 1'b1, 3'd2, 133'h2);
        setV( 2, 1'b1, 1'b1, 1'b0, 3'd3, 133'h3,  1'b1, 2'd1, 1'b1, 3'd3, 133'h3);
        setV( 3, 1'b1, 1'b1, 1'b0, 3'd4, 133'h4,  1'b1, 2'd1, 1'b1, 3'd4, 133'h4);
        setV( 4, 1'b0, 1'b1, 1'b0, 3'd0, 133'h0,  1'b0, 2'd0, 1'b1, 3'd0, 133'h0);
        setV( 5, 1'b1, 1'b0, 1'b0, 3'd5, 133'h11, 1'b1, 2'd1, 1'b1, 3'd5, 133'h11);
        setV( 6, 1'b1, 1'b0, 1'b0, 3'd6, 133'h22, 1'b1, 2'd2, 1'b0, 3'd5, 133'h11);
        setV( 7, 1'b1, 1'b0, 1'b0, 3'd7, 133'h33, 1'b1, 2'd2, 1'b0, 3'd5, 133'h11);
        setV( 8, 1'b1, 1'b1, 1'b0, 3'd7, 133'h33, 1'b1, 2'd1, 1'b1, 3'd6, 133'h22);
        setV( 9, 1'b1, 1'b1, 1'b0, 3'd7, 133'h33, 1'b1, 2'd1, 1'b1, 3'd7, 133'h33);
        setV(10, 1'b0, 1'b1, 1'b0, 3'd0, 133'h0,  1'b0, 2'd0, 1'b1, 3'd0, 133'h0);
        setV(11, 1'b1, 1'b0, 1'b0, 3'd1, 133'h44, 1'b1, 2'd1, 1'b1, 3'd1, 133'h44);
        setV(12, 1'b1, 1'b1, 1'b0, 3'd2, 133'h55, 1'b1, 2'd1, 1'b1, 3'd2, 133'h55);
        setV(13, 1'b0, 1'b0, 1'b0, 3'd0, 133'h0,  1'b1, 2'd1, 1'b1, 3'd2, 133'h55);
        setV(14, 1'b1, 1'b0, 1'b0, 3'd3, 133'h66, 1'b1, 2'd2, 1'b0, 3'd2, 133'h55);
        setV(15, 1'b1, 1'b0, 1'b1, 3'd7, 133'h77, 1'b0, 2'd0, 1'b1, 3'd0, 133'h0);
        setV(16, 1'b1, 1'b0, 1'b0, 3'd4, 133'h88, 1'b1, 2'd1, 1'b1, 3'd4, 133'h88);

        // Directed table on the falling-edge instance
        edgeN();
        for (int i = 0; i < 17; i++) begin
            driveN(tbl[i].inValid, tbl[i].outReady, tbl[i].flush, tbl[i].ctrl, tbl[i].data);
            edgeN();
            chkN($sformatf("vec%0d", i), tbl[i].expValid, tbl[i].expCount, tbl[i].expReady,
                 tbl[i].expCtrl, tbl[i].expData);
        end

        // Asynchronous reset while holding two entries
        driveN(1'b1, 1'b0, 1'b0, 3'd5, 133'hAB);
        edgeN();
        chkN("prereset", 1'b1, 2'd2, 1'b0, 3'd4, 133'h88);
        driveN(1'b0, 1'b0, 1'b0, 3'd0, '0);
        #1 rst = 1'b1;
        #1;
        chkN("midreset", 1'b0, 2'd0, 1'b1, 3'd0, '0);
        chk("midreset.outData", busN.outData, '0);
        @(posedge clk); #1 rst = 1'b0;

        // Capture-edge selection: rising-edge instance vs falling-edge instance
        edgeN();
        driveN(1'b1, 1'b0, 1'b0, 3'd1, 133'hA5);
        busP.inValid = 1'b1; busP.outReady = 1'b0; busP.inCtrl = 3'd1; busP.inData = 133'hA5;
        @(posedge clk); #1;
        chk("edge.pos.valid.rise", DW'(busP.outValid), DW'(1'b1));
        chk("edge.pos.data.rise",  busP.outData, 133'hA5);
        chk("edge.neg.valid.rise", DW'(busN.outValid), DW'(1'b0));
        busP.inValid = 1'b0; busP.outReady = 1'b1;
        @(negedge clk); #1;
        chk("edge.neg.valid.fall", DW'(busN.outValid), DW'(1'b1));
        chk("edge.neg.data.fall",  busN.outData, 133'hA5);
        chk("edge.pos.valid.fall", DW'(busP.outValid), DW'(1'b1));
        driveN(1'b0, 1'b0, 1'b0, 3'd0, '0);
        @(posedge clk); #1;
        chk("edge.pos.valid.rise2", DW'(busP.outValid), DW'(1'b0));
        chk("edge.neg.count.rise2", DW'(busN.count), DW'(2'd1));
        busP.outReady = 1'b0;

        // Randomized run against the queue model
        doReset();
        edgeN();
        for (int n = 0; n < 400; n++) begin
            r   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            d   = r[DW-1:0];
            c   = CW'($urandom);
            iv  = ($urandom_range(3) != 0);
            orr = ($urandom_range(2) != 0);
            fl  = ($urandom_range(15) == 0);
            driveN(iv, orr, fl, c, d);
            if (fl) begin
                model.delete();
            end else begin
                int sz;
                sz = model.size();
                if (sz > 0 && orr) void'(model.pop_front());
                if (iv && sz < 2) begin
                    e.ctrl = c;
                    e.data = d;
                    model.push_back(e);
                end
            end
            edgeN();
            if (model.size() > 0)
                chkN($sformatf("rnd%0d", n), 1'b1, 2'(model.size()), model.size() < 2,
                     model[0].ctrl, model[0].data);
            else
                chkN($sformatf("rnd%0d", n), 1'b0, 2'd0, 1'b1, 3'd0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
